// File: rtl/alu_sequencer.sv
// alu_sequencer: loads a small byte program, then steps it through an
// external combinational ALU, one FETCH/EXEC pair per instruction.
// Instruction byte: [7:4] opcode, [3:0] immediate.
//   0x0-0xB : acc <= alu_y (ALU computes op(acc, {4'h0, imm}))
//   0xC LDL : acc <= {acc[7:4], imm}
//   0xD LDH : acc <= {imm, acc[3:0]}
//   0xE NOP : acc unchanged (SKZ when ALU_SEQ_SKZ_EN is defined:
//             skip the next instruction if acc == 0)
//   0xF HALT: acc unchanged, run ends
// Optional feature macro: ALU_SEQ_SKZ_EN (undefined by default).
module alu_sequencer #(
    parameter int PROG_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    input  logic       clear,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_y,
    output logic [7:0] acc,
    output logic       zero
);

    // pc indexes the program; wptr needs one extra bit to express "full"
    localparam int AW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
    localparam int PW = AW + 1;

    localparam logic [3:0] OP_LDL  = 4'hC;
    localparam logic [3:0] OP_LDH  = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      mem [PROG_DEPTH];
    logic [PW-1:0]   wptr;
    logic [AW-1:0]   pc;
    logic [7:0]      ir;
    logic [7:0]      acc_q;

    logic [3:0]      opcode;
    logic [3:0]      imm;
    logic            skip;
    logic [PW-1:0]   pc_step;
    logic            last;
    logic            load_fire;

    assign opcode = ir[7:4];
    assign imm    = ir[3:0];

`ifdef ALU_SEQ_SKZ_EN
    assign skip = (opcode == OP_NOP) && (acc_q == 8'h00);
`else
    assign skip = 1'b0;
`endif

    // Next pc computed one bit wider so a skip past the end is visible
    assign pc_step   = {1'b0, pc} + (skip ? PW'(2) : PW'(1));
    assign last      = (opcode == OP_HALT) || (pc_step >= wptr);
    assign load_fire = load_valid && load_ready && !clear;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (wptr != '0) ? S_FETCH : S_DONE;
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC:  state_nxt = last ? S_DONE : S_FETCH;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state and registers only (alu_y never reaches a port)
    always_comb begin
        busy       = (state == S_FETCH) || (state == S_EXEC);
        done       = (state == S_DONE);
        load_ready = (state == S_IDLE) && (wptr < PW'(PROG_DEPTH));
        alu_a      = 8'h00;
        alu_b      = 8'h00;
        alu_op     = 4'hF;
        if (state == S_EXEC) begin
            alu_a  = acc_q;
            alu_b  = {4'h0, imm};
            alu_op = opcode;
        end
    end

    assign acc  = acc_q;
    assign zero = (acc_q == 8'h00);

    // Program store; contents survive reset and clear
    always_ff @(posedge clk) begin
        if (rst_n && load_fire) mem[wptr[AW-1:0]] <= load_data;
    end

    // Datapath: write pointer, program counter, instruction and accumulator
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            pc    <= '0;
            ir    <= 8'h00;
            acc_q <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clear)          wptr <= '0;
                    else if (load_fire) wptr <= wptr + PW'(1);
                    if (start && wptr != '0) pc <= '0;
                end
                S_FETCH: ir <= mem[pc];
                S_EXEC: begin
                    case (opcode)
                        OP_LDL:  acc_q <= {acc_q[7:4], imm};
                        OP_LDH:  acc_q <= {imm, acc_q[3:0]};
                        OP_NOP:  acc_q <= acc_q;
                        OP_HALT: acc_q <= acc_q;
                        default: acc_q <= alu_y;
                    endcase
                    if (!last) pc <= pc_step[AW-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small combinational ALU model.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       clear;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_op;
    logic [7:0] alu_y;
    logic [7:0] acc;
    logic       zero;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] acc_hist [0:31];
    logic [3:0] op_hist  [0:31];
    int done_at, busy_cnt, done_cnt;

    alu_sequencer #(.PROG_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .clear(clear), .start(start), .busy(busy), .done(done),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
        .acc(acc), .zero(zero)
    );

    always #5 clk = ~clk;

    // External ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, others pass A
    always_comb begin
        case (alu_op)
            4'h0:    alu_y = alu_a + alu_b;
            4'h1:    alu_y = alu_a - alu_b;
            4'h2:    alu_y = alu_a & alu_b;
            4'h3:    alu_y = alu_a | alu_b;
            4'h4:    alu_y = alu_a ^ alu_b;
            default: alu_y = alu_a;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] b);
        load_valid = 1'b1;
        load_data  = b;
        step();
        load_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Pulse start and watch a bounded window; cycle 1 is the first after the start edge
    task automatic run(input int maxc);
        start = 1'b1;
        step();
        start = 1'b0;
        done_at  = -1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 1; c <= maxc; c++) begin
            acc_hist[c] = acc;
            op_hist[c]  = alu_op;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            step();
        end
    endtask

    initial begin
        rst_n = 1'b1; load_valid = 1'b0; load_data = 8'h00;
        clear = 1'b0; start = 1'b0;
        #1;

        // Reset state
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_acc", acc, 8'h00);
        chk("rst_zero", zero, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", load_ready, 1'b1);
        chk("rst_op", alu_op, 4'hF);
        chk("rst_ab", {alu_a, alu_b}, 16'h0000);

        // LDH 3, LDL 5, ADD 1
        load(8'hD3); load(8'hC5); load(8'h01);
        run(20);
        chk("p1_op_fetch", op_hist[1], 4'hF);
        chk("p1_op_exec", op_hist[2], 4'hD);
        chk("p1_acc1", acc_hist[3], 8'h30);
        chk("p1_acc2", acc_hist[5], 8'h35);
        chk("p1_acc3", acc_hist[7], 8'h36);
        chk("p1_done_at", done_at, 7);
        chk("p1_busy", busy_cnt, 6);
        chk("p1_done_cnt", done_cnt, 1);

        // Wrap to zero: F6 -> FF -> 00
        pulse_clear();
        load(8'hDF); load(8'hCF); load(8'h01);
        run(20);
        chk("p2_acc2", acc_hist[5], 8'hFF);
        chk("p2_acc3", acc_hist[7], 8'h00);
        chk("p2_zero", zero, 1'b1);
        chk("p2_done_cnt", done_cnt, 1);

        // Fill program memory, HALT at byte 2
        pulse_clear();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("full_ready15", load_ready, 1'b1);
            load(i == 0 ? 8'h03 : i == 1 ? 8'h02 : i == 2 ? 8'hF0 : 8'h01);
        end
        chk("full_ready", load_ready, 1'b0);
        load(8'h01);
        chk("full_ready17", load_ready, 1'b0);
        run(20);
        chk("halt_done_at", done_at, 7);
        chk("halt_busy", busy_cnt, 6);
        chk("halt_acc", acc, 8'h05);
        run(20);
        chk("rerun_acc", acc, 8'h0A);
        chk("rerun_done_cnt", done_cnt, 1);

        // Reset in the middle of EXEC
        pulse_clear();
        load(8'h01); load(8'h01); load(8'h01);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("mid_exec_busy", busy, 1'b1);
        chk("mid_exec_op", alu_op, 4'h0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_acc", acc, 8'h00);
        chk("mid_rst_ready", load_ready, 1'b1);
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) done_cnt++;
            step();
        end
        chk("mid_rst_nodone", done_cnt, 0);

        // Empty program: done right away, never busy
        run(6);
        chk("empty_done_at", done_at, 1);
        chk("empty_busy", busy_cnt, 0);

        // Clear beats a simultaneous load
        clear = 1'b1; load_valid = 1'b1; load_data = 8'h01;
        step();
        clear = 1'b0; load_valid = 1'b0;
        run(6);
        chk("clr_load_done_at", done_at, 1);
        chk("clr_load_acc", acc, 8'h00);

        // LDL 0, NOP/SKZ, ADD 5, ADD 3
        load(8'hC0); load(8'hE0); load(8'h05); load(8'h03);
        run(24);
        chk("skz_acc1", acc_hist[3], 8'h00);
`ifdef ALU_SEQ_SKZ_EN
        chk("skz_final", acc, 8'h03);
        chk("skz_done_at", done_at, 7);
`else
        chk("nop_final", acc, 8'h08);
        chk("nop_done_at", done_at, 9);
`endif
        chk("skz_done_cnt", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
